regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//  Shares the register file's single write port (5-to-32 write-enable decoder
//  plus data bus) between two writeback requesters: req0 = ALU/EX result,
//  req1 = load/MEM result. Arbitrates, registers the winner in a one-entry
//  issue stage and drives decoder address/enable and write data.
//  Suppresses writes to R0 and freezes on a pipeline hold.
// PARAMETERS
//  ADDR_W    5   register address width; the decoder input is 5 bits wide
//  DATA_W    32  write data width
//  PRIO_MODE 0   0 = round-robin; 1 = fixed priority, req0 always wins
//  DROP_R0   1   1 = accepted writes to address 0 never assert wr_en
// PORTS
//  clk         in   1       rising-edge clock
//  reset       in   1       asynchronous, active-high reset
//  hold        in   1       pipeline stall; freezes the write port
//  req0_valid  in   1       requester 0 has a write
//  req0_addr   in   ADDR_W  requester 0 destination register
//  req0_data   in   DATA_W  requester 0 write data
//  req0_ready  out  1       requester 0 write accepted this cycle
//  req1_valid  in   1       requester 1 has a write
//  req1_addr   in   ADDR_W  requester 1 destination register
//  req1_data   in   DATA_W  requester 1 write data
//  req1_ready  out  1       requester 1 write accepted this cycle
//  wr_en       out  1       to decoder enable E
//  wr_addr     out  ADDR_W  to decoder select D
//  wr_data     out  DATA_W  to register file data input
//  wr_src      out  1       source of the issued write (0 = req0, 1 = req1)
// BEHAVIOUR
//  - Handshake: a write transfers when reqN_valid & reqN_ready at a rising edge.
//    reqN_ready = grantN & ~hold. Ready is combinational from valid/hold/pointer.
//    Ready never asserts without valid.
//  - Grant: a single valid requester wins. When both are valid:
//    PRIO_MODE=1 grants req0.
//    PRIO_MODE=0 grants the requester not granted last; the pointer updates only
//    on an actual transfer.
//  - Issue stage (stg_v, stg_addr, stg_data, stg_src, stg_r0): loads the
//    granted request on an edge with hold=0; clears stg_v if no request.
//    On hold=1 every field holds its value.
//  - Output:
//      wr_en   = stg_v & ~hold & ~(DROP_R0 & stg_r0), combinational on hold.
//      wr_addr = stg_addr, wr_data = stg_data, wr_src = stg_src.
//  - States (derived from stg_v, hold):
//      EMPTY (stg_v=0); ISSUE (stg_v=1, hold=0); STALL (stg_v=1, hold=1).
//    Transitions:
//      EMPTY->ISSUE on a transfer.
//      ISSUE->ISSUE on a new transfer; ISSUE->EMPTY with no request.
//      ISSUE/EMPTY->STALL or EMPTY when hold rises.
//      STALL->ISSUE when hold falls.
//  - Latency: a request accepted at edge N gives wr_en=1 during cycle N+1; the
//    register file captures it at edge N+1. Throughput is one write per cycle
//    with no bubble.
//  - R0: with DROP_R0=1, an addr 0 request is accepted and consumes a slot and
//    RR turn, but wr_en stays 0 during its issue cycle.
//  - Same address on both requesters in the same cycle: ordering follows
//    grant; the loser issues in the following slot, so it is the final value.
//  - Reset (async):
//      stg_v=0 immediately, so wr_en=0.
//      wr_addr=0, wr_data=0, wr_src=0.
//      RR pointer = 1, so req0 wins first.
//      Readies follow the combinational rule.
//    An in-flight write is discarded.
//  - hold=1 and reset=0: no transfer, readies 0, wr_en 0, outputs stable.
// TESTING
//  T1 Single write: req0 valid, addr 5, data 0xDEADBEEF.
//     -> req0_ready=1 that cycle.
//     -> Next cycle: wr_en=1, wr_addr=5, wr_data=0xDEADBEEF, wr_src=0.
//  T2 Round-robin: both valid for 4 cycles, req0 addr 1, req1 addr 2.
//     -> Grants alternate 0,1,0,1 after reset.
//     -> wr_addr sequence 1,2,1,2 with wr_en high for 4 consecutive cycles.
//  T3 Hold: write pending, hold=1 for 3 cycles.
//     -> wr_en=0 and readies 0 throughout; wr_addr/wr_data unchanged.
//     -> Cycle after hold falls: wr_en=1 with the same values.
//  T4 R0 drop: req1 addr 0, data 0x1234.
//     -> req1_ready=1; wr_en stays 0 the next cycle.
//     -> Following req0 addr 7 issues normally.
//  T5 Reset mid-issue: assert reset while wr_en=1.
//     -> wr_en=0 without waiting for a clock edge; outputs zero.
//     -> After release with both valid, req0 is granted first.
//  T6 PRIO_MODE=1: both valid for 3 cycles.
//     -> req0 granted every cycle; req1_ready stays 0 until req0_valid drops.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
// Purpose : request and write-port bundle between the two writeback requesters and the register file.
// Latency : n/a (wires only).
// Backpress: reqN_ready is driven by the arbiter (slave) and read by the requesters (master).
// Ports   : req0_* / req1_* valid-ready write requests, wr_* decoder enable/select and data.
interface regfile_write_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;

    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_src;

    // Requester / register-file side.
    modport master (
        output req0_valid, req0_addr, req0_data,
        input  req0_ready,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready,
        input  wr_en, wr_addr, wr_data, wr_src
    );

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_addr, req0_data,
        output req0_ready,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready,
        output wr_en, wr_addr, wr_data, wr_src
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Purpose : arbitrates ALU (req0) and load (req1) writebacks onto the single register-file write port.
// Latency : request accepted at edge N drives wr_en during cycle N+1; one write per cycle, no bubble.
// Backpress: reqN_ready = grantN & ~hold; hold freezes the issue stage and forces wr_en low.
// Ports   : clk, reset (async active-high), hold (pipeline stall), bus (slave modport):
//           req0/req1 valid/addr/data/ready, wr_en/wr_addr/wr_data/wr_src to decoder and data input.
module regfile_write_arbiter #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int PRIO_MODE = 0,
    parameter int DROP_R0   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    hold,
    regfile_write_arbiter_if.slave  bus
);

    localparam bit PRIO_FIXED = (PRIO_MODE != 0);
    localparam bit DROP_EN    = (DROP_R0 != 0);

    // One issue-stage entry. r0 is precomputed at load time so the output
    // enable does not need an address compare after the register.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              src;
        logic              r0;
    } stg_t;

    // Externally visible phase of the write port; STALL depends on hold
    // combinationally, so the phase is decoded from stg_v and hold rather
    // than stored.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ISSUE = 2'd1,
        STALL = 2'd2
    } phase_t;

    stg_t   stg_q;
    stg_t   stg_d;
    logic   stg_v_q;
    logic   stg_v_d;
    // Requester granted on the most recent transfer; reset to 1 so req0
    // takes the first contested slot.
    logic   last_q;
    logic   last_d;
    phase_t phase;

    logic   grant0;
    logic   grant1;
    logic   ready0;
    logic   ready1;
    logic   xfer;
    stg_t   req0_ent;
    stg_t   req1_ent;

    // ------------------------------------------------------------------
    // Grant: a lone valid requester always wins; on contention fixed mode
    // picks req0 and round-robin picks whoever was not granted last.
    // ------------------------------------------------------------------
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            if (PRIO_FIXED || last_q) begin
                grant0 = 1'b1;
            end else begin
                grant1 = 1'b1;
            end
        end else begin
            grant0 = bus.req0_valid;
            grant1 = bus.req1_valid;
        end
    end

    assign ready0 = grant0 & ~hold;
    assign ready1 = grant1 & ~hold;
    // Grants are one-hot and imply valid, so either ready means a transfer.
    assign xfer   = ready0 | ready1;

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;

    assign req0_ent = '{addr: bus.req0_addr,
                        data: bus.req0_data,
                        src:  1'b0,
                        r0:   (bus.req0_addr == '0)};
    assign req1_ent = '{addr: bus.req1_addr,
                        data: bus.req1_data,
                        src:  1'b1,
                        r0:   (bus.req1_addr == '0)};

    // ------------------------------------------------------------------
    // Phase decode
    // ------------------------------------------------------------------
    always_comb begin
        phase = EMPTY;
        if (stg_v_q) begin
            phase = hold ? STALL : ISSUE;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. While hold is high nothing moves, including the
    // round-robin pointer. Without hold the stage either takes the winner
    // or drains; the payload fields are only rewritten on a transfer so
    // wr_addr/wr_data keep showing the last issued write when idle.
    // ------------------------------------------------------------------
    always_comb begin
        stg_v_d = stg_v_q;
        stg_d   = stg_q;
        last_d  = last_q;
        case (phase)
            EMPTY, ISSUE: begin
                if (!hold) begin
                    stg_v_d = xfer;
                    if (ready0) begin
                        stg_d  = req0_ent;
                        last_d = 1'b0;
                    end else if (ready1) begin
                        stg_d  = req1_ent;
                        last_d = 1'b1;
                    end
                end
            end
            STALL: begin
                stg_v_d = stg_v_q;
            end
            default: begin
                stg_v_d = stg_v_q;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers; reset discards any in-flight write.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stg_v_q <= 1'b0;
            stg_q   <= '0;
            last_q  <= 1'b1;
        end else begin
            stg_v_q <= stg_v_d;
            stg_q   <= stg_d;
            last_q  <= last_d;
        end
    end

    // ------------------------------------------------------------------
    // Write port. An R0 write still occupies its slot but never enables
    // the decoder, so the hardwired-zero register is never disturbed.
    // ------------------------------------------------------------------
    assign bus.wr_en   = (phase == ISSUE) & ~(DROP_EN & stg_q.r0);
    assign bus.wr_addr = stg_q.addr;
    assign bus.wr_data = stg_q.data;
    assign bus.wr_src  = stg_q.src;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic hold = 1'b0;

    always #5 clk = ~clk;

    regfile_write_arbiter_if #(.ADDR_W(5), .DATA_W(32)) bus0 ();
    regfile_write_arbiter_if #(.ADDR_W(5), .DATA_W(32)) bus1 ();

    regfile_write_arbiter #(.ADDR_W(5), .DATA_W(32), .PRIO_MODE(0), .DROP_R0(1)) u_rr (
        .clk   (clk),
        .reset (reset),
        .hold  (hold),
        .bus   (bus0)
    );

    regfile_write_arbiter #(.ADDR_W(5), .DATA_W(32), .PRIO_MODE(1), .DROP_R0(1)) u_fp (
        .clk   (clk),
        .reset (reset),
        .hold  (hold),
        .bus   (bus1)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        hold;
        logic        v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        r0;
        logic        r1;
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        src;
    } vec_t;

    vec_t vt[10];

    // Reference model: expected issue slot per instance plus the register
    // file contents implied by the accepted write order.
    typedef struct {
        logic        v;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        src;
        logic        last;
    } mdl_t;

    mdl_t        mdl[2];
    logic [31:0] rf_ref[2][32];
    logic [31:0] rf_dut[2][32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic h, input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1);
        hold = h;
        bus0.req0_valid = v0; bus0.req0_addr = a0; bus0.req0_data = d0;
        bus0.req1_valid = v1; bus0.req1_addr = a1; bus0.req1_data = d1;
        bus1.req0_valid = v0; bus1.req0_addr = a0; bus1.req0_data = d0;
        bus1.req1_valid = v1; bus1.req1_addr = a1; bus1.req1_data = d1;
    endtask

    function automatic vec_t mk(input logic h, input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                                input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                                input logic r0, input logic r1, input logic en,
                                input logic [4:0] ad, input logic [31:0] da, input logic sr);
        vec_t v;
        v.hold = h; v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
        v.r0 = r0; v.r1 = r1; v.en = en; v.addr = ad; v.data = da; v.src = sr;
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mdl[k] = '{v: 1'b0, addr: 5'd0, data: 32'd0, src: 1'b0, last: 1'b1};
            for (int r = 0; r < 32; r++) begin
                rf_ref[k][r] = 32'd0;
                rf_dut[k][r] = 32'd0;
            end
        end
    endtask

    // Compare instance k against the model for the current cycle's inputs,
    // then advance the model across the coming rising edge.
    task automatic model_step(input int k);
        int          win;
        logic        a_r0, a_r1, a_en, a_src;
        logic [4:0]  a_addr;
        logic [31:0] a_data;
        logic        v0, v1;
        logic [4:0]  a0, a1;
        logic [31:0] d0, d1;
        v0 = bus0.req0_valid; a0 = bus0.req0_addr; d0 = bus0.req0_data;
        v1 = bus0.req1_valid; a1 = bus0.req1_addr; d1 = bus0.req1_data;
        if (k == 0) begin
            a_r0 = bus0.req0_ready; a_r1 = bus0.req1_ready; a_en = bus0.wr_en;
            a_addr = bus0.wr_addr; a_data = bus0.wr_data; a_src = bus0.wr_src;
        end else begin
            a_r0 = bus1.req0_ready; a_r1 = bus1.req1_ready; a_en = bus1.wr_en;
            a_addr = bus1.wr_addr; a_data = bus1.wr_data; a_src = bus1.wr_src;
        end
        if (v0 && v1) win = (k == 1 || mdl[k].last) ? 0 : 1;
        else if (v0) win = 0;
        else if (v1) win = 1;
        else win = -1;

        chk($sformatf("rnd%0d req0_ready", k), a_r0, !hold && win == 0);
        chk($sformatf("rnd%0d req1_ready", k), a_r1, !hold && win == 1);
        chk($sformatf("rnd%0d wr_en", k), a_en, mdl[k].v && !hold && mdl[k].addr != 5'd0);
        chk($sformatf("rnd%0d wr_addr", k), a_addr, mdl[k].addr);
        chk($sformatf("rnd%0d wr_data", k), a_data, mdl[k].data);
        chk($sformatf("rnd%0d wr_src", k), a_src, mdl[k].src);

        if (a_en) rf_dut[k][a_addr] = a_data;
        if (!hold) begin
            if (win >= 0) begin
                mdl[k].v    = 1'b1;
                mdl[k].addr = (win == 0) ? a0 : a1;
                mdl[k].data = (win == 0) ? d0 : d1;
                mdl[k].src  = (win == 1);
                mdl[k].last = (win == 1);
                if (mdl[k].addr != 5'd0) rf_ref[k][mdl[k].addr] = mdl[k].data;
            end else begin
                mdl[k].v = 1'b0;
            end
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);

        // Reset state.
        #1;
        chk("rst wr_en", bus0.wr_en, 1'b0);
        chk("rst wr_addr", bus0.wr_addr, 5'd0);
        chk("rst wr_data", bus0.wr_data, 32'd0);
        chk("rst wr_src", bus0.wr_src, 1'b0);
        chk("rst req0_ready", bus0.req0_ready, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Round-robin pairs, single write, R0 drop and the write after it.
        //          h  v0 a0  d0            v1 a1  d1        r0 r1 en addr data          src
        vt[0] = mk(0, 1, 1, 32'h11,       1, 2, 32'h22,   1, 0, 0, 0, 32'h0,        0);
        vt[1] = mk(0, 1, 1, 32'h11,       1, 2, 32'h22,   0, 1, 1, 1, 32'h11,       0);
        vt[2] = mk(0, 1, 1, 32'h11,       1, 2, 32'h22,   1, 0, 1, 2, 32'h22,       1);
        vt[3] = mk(0, 1, 1, 32'h11,       1, 2, 32'h22,   0, 1, 1, 1, 32'h11,       0);
        vt[4] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,    0, 0, 1, 2, 32'h22,       1);
        vt[5] = mk(0, 1, 5, 32'hDEADBEEF, 0, 0, 32'h0,    1, 0, 0, 2, 32'h22,       1);
        vt[6] = mk(0, 0, 0, 32'h0,        1, 0, 32'h1234, 0, 1, 1, 5, 32'hDEADBEEF, 0);
        vt[7] = mk(0, 1, 7, 32'h77,       0, 0, 32'h0,    1, 0, 0, 0, 32'h1234,     1);
        vt[8] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,    0, 0, 1, 7, 32'h77,       0);
        vt[9] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,    0, 0, 0, 7, 32'h77,       0);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(vt[i].hold, vt[i].v0, vt[i].a0, vt[i].d0, vt[i].v1, vt[i].a1, vt[i].d1);
            #1;
            chk($sformatf("vec%0d req0_ready", i), bus0.req0_ready, vt[i].r0);
            chk($sformatf("vec%0d req1_ready", i), bus0.req1_ready, vt[i].r1);
            chk($sformatf("vec%0d wr_en", i), bus0.wr_en, vt[i].en);
            chk($sformatf("vec%0d wr_addr", i), bus0.wr_addr, vt[i].addr);
            chk($sformatf("vec%0d wr_data", i), bus0.wr_data, vt[i].data);
            chk($sformatf("vec%0d wr_src", i), bus0.wr_src, vt[i].src);
        end

        // Hold with a write pending.
        @(negedge clk);
        drive(0, 1, 9, 32'h99, 0, 0, 0);
        #1 chk("hold accept", bus0.req0_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1, 1, 3, 32'h33, 1, 4, 32'h44);
            #1;
            chk("hold req0_ready", bus0.req0_ready, 1'b0);
            chk("hold req1_ready", bus0.req1_ready, 1'b0);
            chk("hold wr_en", bus0.wr_en, 1'b0);
            chk("hold wr_addr", bus0.wr_addr, 5'd9);
            chk("hold wr_data", bus0.wr_data, 32'h99);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("unhold wr_en", bus0.wr_en, 1'b1);
        chk("unhold wr_addr", bus0.wr_addr, 5'd9);
        chk("unhold wr_data", bus0.wr_data, 32'h99);
        chk("unhold wr_src", bus0.wr_src, 1'b0);
        @(negedge clk);
        #1 chk("drain wr_en", bus0.wr_en, 1'b0);

        // Reset while a write is issuing.
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 4, 32'h44);
        #1 chk("t5 req1_ready", bus0.req1_ready, 1'b1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1 chk("t5 pre wr_en", bus0.wr_en, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("t5 async wr_en", bus0.wr_en, 1'b0);
        chk("t5 async wr_addr", bus0.wr_addr, 5'd0);
        chk("t5 async wr_data", bus0.wr_data, 32'd0);
        chk("t5 async wr_src", bus0.wr_src, 1'b0);

        // Release with both valid: req0 first on both; fixed priority keeps req0.
        @(negedge clk);
        reset = 1'b0;
        drive(0, 1, 1, 32'h11, 1, 2, 32'h22);
        #1;
        chk("t5 rr req0_ready", bus0.req0_ready, 1'b1);
        chk("t5 rr req1_ready", bus0.req1_ready, 1'b0);
        chk("t6 c1 req0_ready", bus1.req0_ready, 1'b1);
        chk("t6 c1 req1_ready", bus1.req1_ready, 1'b0);
        @(negedge clk);
        #1;
        chk("t5 rr2 req1_ready", bus0.req1_ready, 1'b1);
        chk("t6 c2 req0_ready", bus1.req0_ready, 1'b1);
        chk("t6 c2 req1_ready", bus1.req1_ready, 1'b0);
        chk("t6 c2 wr_addr", bus1.wr_addr, 5'd1);
        @(negedge clk);
        #1;
        chk("t6 c3 req1_ready", bus1.req1_ready, 1'b0);
        chk("t6 c3 wr_en", bus1.wr_en, 1'b1);
        chk("t6 c3 wr_src", bus1.wr_src, 1'b0);
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 2, 32'h22);
        #1 chk("t6 c4 req1_ready", bus1.req1_ready, 1'b1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("t6 c5 wr_en", bus1.wr_en, 1'b1);
        chk("t6 c5 wr_addr", bus1.wr_addr, 5'd2);
        chk("t6 c5 wr_src", bus1.wr_src, 1'b1);

        // Randomized run against the reference model, both priority modes.
        @(negedge clk);
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            logic       h, v0, v1;
            logic [4:0] a0, a1;
            @(negedge clk);
            h  = ($urandom_range(0, 4) == 0);
            v0 = ($urandom_range(0, 2) != 0);
            v1 = ($urandom_range(0, 2) != 0);
            a0 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            drive(h, v0, a0, $urandom, v1, a1, $urandom);
            #1;
            model_step(0);
            model_step(1);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 0, 0, 0);
            #1;
            model_step(0);
            model_step(1);
        end
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 32; r++) begin
                chk($sformatf("rf%0d r%0d", k, r), rf_dut[k][r], rf_ref[k][r]);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
